// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
//   REG_ADDR_W : register address width
//   NUM_REGS   : architectural register count (scoreboard depth)
//   WB_DATA_W  : data width carried in wb_req_t
//   wb_req_t   : one writeback request {valid, addr, data}
package regfile_wb_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned WB_DATA_W  = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback / reservation / register-file bus of regfile_wb_arbiter.
//   master : writeback requesters, decode reservation, register file side
//   slave  : the arbiter itself
// Optional bypass ports exist only when WB_BYPASS_EN is defined.
interface regfile_wb_arbiter_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned XLEN = 32
);
    import regfile_wb_arbiter_pkg::*;

    logic [NREQ-1:0]            req_valid;
    logic [NREQ*REG_ADDR_W-1:0] req_addr;
    logic [NREQ*XLEN-1:0]       req_data;
    logic [NREQ-1:0]            req_ready;
    logic                       rsv_valid;
    logic [REG_ADDR_W-1:0]      rsv_addr;
    logic                       rsv_ready;
    logic [NUM_REGS-1:0]        busy;
    logic                       rf_we;
    logic [REG_ADDR_W-1:0]      rf_addr;
    logic [XLEN-1:0]            rf_data;
`ifdef WB_BYPASS_EN
    logic [REG_ADDR_W-1:0]      byp_addr_a;
    logic [REG_ADDR_W-1:0]      byp_addr_b;
    logic                       byp_hit_a;
    logic                       byp_hit_b;
    logic [XLEN-1:0]            byp_data_a;
    logic [XLEN-1:0]            byp_data_b;
`endif

    modport master (
        output req_valid, req_addr, req_data, rsv_valid, rsv_addr,
`ifdef WB_BYPASS_EN
        output byp_addr_a, byp_addr_b,
        input  byp_hit_a, byp_hit_b, byp_data_a, byp_data_b,
`endif
        input  req_ready, rsv_ready, busy, rf_we, rf_addr, rf_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, rsv_valid, rsv_addr,
`ifdef WB_BYPASS_EN
        input  byp_addr_a, byp_addr_b,
        output byp_hit_a, byp_hit_b, byp_data_a, byp_data_b,
`endif
        output req_ready, rsv_ready, busy, rf_we, rf_addr, rf_data
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// N-wide round-robin arbiter with a registered last-grant pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_req      : request vector
//   o_gnt_c    : one-hot combinational grant; search starts at r_ptr+1
// The pointer moves to the granted index and resets to N-1 so that
// index 0 has first priority.
module regfile_wb_arbiter_rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt_c
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // Scan N positions starting just after the last winner.
    always_comb begin
        o_gnt_c   = '0;
        w_ptr_nxt = r_ptr;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_idx = PTR_W'((32'(r_ptr) + k) % N);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_gnt_c[w_idx] = 1'b1;
                w_ptr_nxt      = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PTR_W'(N - 1);
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with destination scoreboard.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : regfile_wb_arbiter_if.slave
//                req_*  -> round-robin shared write port (ready is combinational)
//                rsv_*  -> decode reservation into the busy scoreboard
//                rf_*   -> registered register-file write stage
// Optional feature macro: WB_BYPASS_EN adds combinational forwarding of
// the write stage to two decode read addresses.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    logic [NREQ-1:0]       w_req;
    logic [NREQ-1:0]       w_gnt;
    logic                  w_xfer;
    logic [REG_ADDR_W-1:0] w_sel_addr;
    logic [XLEN-1:0]       w_sel_data;
    logic                  w_rsv_ready;
    logic                  w_rsv_set;
    logic [NUM_REGS-1:0]   w_busy_nxt;
    wb_req_t               r_wb;
    logic [NUM_REGS-1:0]   r_busy;

    // No grants while reset is held.
    assign w_req = bus.req_valid & {NREQ{rst_n}};

    regfile_wb_arbiter_rr_arbiter #(.N(NREQ)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (w_req),
        .o_gnt_c (w_gnt)
    );

    assign bus.req_ready = w_gnt;
    assign w_xfer        = |w_gnt;

    // One-hot mux of the winning request.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr = bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                w_sel_data = bus.req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Write stage; x0 transfers complete the handshake but never write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb <= '0;
        end else if (w_xfer) begin
            r_wb.valid <= (w_sel_addr != '0);
            r_wb.addr  <= w_sel_addr;
            r_wb.data  <= WB_DATA_W'(w_sel_data);
        end else begin
            r_wb.valid <= 1'b0;
        end
    end

    assign bus.rf_we   = r_wb.valid;
    assign bus.rf_addr = r_wb.addr;
    assign bus.rf_data = XLEN'(r_wb.data);

    // Reservation is always accepted for x0, which is never tracked.
    assign w_rsv_ready   = !r_busy[bus.rsv_addr] || (bus.rsv_addr == '0);
    assign w_rsv_set     = bus.rsv_valid && w_rsv_ready && (bus.rsv_addr != '0);
    assign bus.rsv_ready = w_rsv_ready;

    // Clear on the edge the register file captures; set and clear of the
    // same bit cannot coincide because a busy bit refuses reservation.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wb.valid) begin
            w_busy_nxt[r_wb.addr] = 1'b0;
        end
        if (w_rsv_set) begin
            w_busy_nxt[bus.rsv_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign bus.busy = r_busy;

`ifdef WB_BYPASS_EN
    // Forward the write stage to decode one cycle before the RF holds it.
    assign bus.byp_hit_a  = r_wb.valid && (r_wb.addr == bus.byp_addr_a) && (bus.byp_addr_a != '0);
    assign bus.byp_hit_b  = r_wb.valid && (r_wb.addr == bus.byp_addr_b) && (bus.byp_addr_b != '0);
    assign bus.byp_data_a = XLEN'(r_wb.data);
    assign bus.byp_data_b = XLEN'(r_wb.data);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NREQ=3, XLEN=32).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_regfile_wb_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    regfile_wb_arbiter_if #(.NREQ(3), .XLEN(32)) bus ();

    regfile_wb_arbiter #(.NREQ(3), .XLEN(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp_gnt [6];
        exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b100;
        exp_gnt[3] = 3'b001; exp_gnt[4] = 3'b010; exp_gnt[5] = 3'b100;
        n_checks = 0;
        n_fail   = 0;

        // Reset held with every requester valid.
        rst_n         = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_addr  = {5'd3, 5'd2, 5'd1};
        bus.req_data  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        bus.rsv_valid = 1'b0;
        bus.rsv_addr  = 5'd0;
`ifdef WB_BYPASS_EN
        bus.byp_addr_a = 5'd0;
        bus.byp_addr_b = 5'd0;
`endif
        #1;
        check("rst_ready", 64'(bus.req_ready), 64'h0);
        check("rst_we",    64'(bus.rf_we),     64'h0);
        check("rst_busy",  64'(bus.busy),      64'h0);
        check("rst_addr",  64'(bus.rf_addr),   64'h0);
        check("rst_data",  64'(bus.rf_data),   64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Round-robin with all three valid: grants 0,1,2,0,1,2.
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_gnt%0d", k), 64'(bus.req_ready), 64'(exp_gnt[k]));
            if (k == 0) begin
                check("rr_we0", 64'(bus.rf_we), 64'h0);
            end else begin
                check($sformatf("rr_we%0d", k),   64'(bus.rf_we),   64'h1);
                check($sformatf("rr_addr%0d", k), 64'(bus.rf_addr), 64'(((k - 1) % 3) + 1));
            end
            next_cycle();
        end
        bus.req_valid = 3'b000;
        #1;
        check("rr_addr_last", 64'(bus.rf_addr), 64'd3);
        check("rr_data_last", 64'(bus.rf_data), 64'h3333_3333);
        check("rr_busy",      64'(bus.busy),    64'h0);
        next_cycle();
        check("rr_we_idle", 64'(bus.rf_we), 64'h0);

        // Reserve x5 (cycle t).
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd5;
        #1;
        check("sb_rsv_ready", 64'(bus.rsv_ready), 64'h1);
        next_cycle();
        // Cycle t+1: x5 busy, re-reservation refused, requester 1 writes x5.
        check("sb_busy_set", 64'(bus.busy), 64'h20);
        check("sb_rerсv_blk", 64'(bus.rsv_ready), 64'h0);
        bus.req_valid = 3'b010;
        bus.req_addr  = {5'd0, 5'd5, 5'd0};
        bus.req_data  = {32'h0, 32'hDEAD_BEEF, 32'h0};
        #1;
        check("sb_gnt1", 64'(bus.req_ready), 64'h2);
        next_cycle();
        // Cycle t+2: write stage active, still busy.
        bus.req_valid = 3'b000;
        #1;
        check("sb_we",       64'(bus.rf_we),     64'h1);
        check("sb_addr",     64'(bus.rf_addr),   64'd5);
        check("sb_data",     64'(bus.rf_data),   64'hDEAD_BEEF);
        check("sb_busy_hold",64'(bus.busy),      64'h20);
        check("sb_rsv_blk2", 64'(bus.rsv_ready), 64'h0);
        next_cycle();
        // Cycle t+3: cleared, re-reservation accepted (held rsv_valid).
        check("sb_we_off",   64'(bus.rf_we),     64'h0);
        check("sb_busy_clr", 64'(bus.busy),      64'h0);
        check("sb_rsv_ok",   64'(bus.rsv_ready), 64'h1);
        next_cycle();
        bus.rsv_valid = 1'b0;
        check("sb_busy_reset", 64'(bus.busy), 64'h20);

        // x0 write from requester 2 plus a reservation of x0.
        bus.req_valid = 3'b100;
        bus.req_addr  = {5'd0, 5'd0, 5'd0};
        bus.req_data  = {32'h0000_1234, 32'h0, 32'h0};
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd0;
        #1;
        check("x0_gnt",       64'(bus.req_ready), 64'h4);
        check("x0_rsv_ready", 64'(bus.rsv_ready), 64'h1);
        next_cycle();
        bus.req_valid = 3'b000;
        bus.rsv_valid = 1'b0;
        #1;
        check("x0_we",   64'(bus.rf_we), 64'h0);
        check("x0_busy", 64'(bus.busy),  64'h20);

`ifdef WB_BYPASS_EN
        // Bypass while the write stage holds x7.
        bus.req_valid = 3'b001;
        bus.req_addr  = {5'd0, 5'd0, 5'd7};
        bus.req_data  = {32'h0, 32'h0, 32'h0000_0077};
        next_cycle();
        bus.req_valid  = 3'b000;
        bus.byp_addr_a = 5'd7;
        bus.byp_addr_b = 5'd0;
        #1;
        check("byp_hit_a",  64'(bus.byp_hit_a),  64'h1);
        check("byp_data_a", 64'(bus.byp_data_a), 64'h77);
        check("byp_hit_b",  64'(bus.byp_hit_b),  64'h0);
        next_cycle();
        check("byp_hit_a_off", 64'(bus.byp_hit_a), 64'h0);
        bus.byp_addr_a = 5'd0;
`endif

        // Mid-operation reset during an rf_we cycle.
        next_cycle();
        bus.req_valid = 3'b001;
        bus.req_addr  = {5'd0, 5'd0, 5'd9};
        bus.req_data  = {32'h0, 32'h0, 32'h0000_CAFE};
        #1;
        check("mr_gnt", 64'(bus.req_ready), 64'h1);
        next_cycle();
        bus.req_valid = 3'b000;
        #1;
        check("mr_we_pre",   64'(bus.rf_we),   64'h1);
        check("mr_addr_pre", 64'(bus.rf_addr), 64'd9);
        rst_n = 1'b0;
        #1;
        check("mr_we",   64'(bus.rf_we),   64'h0);
        check("mr_busy", 64'(bus.busy),    64'h0);
        check("mr_data", 64'(bus.rf_data), 64'h0);
        bus.req_valid = 3'b111;
        #1;
        check("mr_ready", 64'(bus.req_ready), 64'h0);
        @(posedge clk);
        #1;
        check("mr_we_edge", 64'(bus.rf_we), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mr_first_gnt", 64'(bus.req_ready), 64'h1);
        next_cycle();
        bus.req_valid = 3'b000;
        #1;
        check("mr_post_addr", 64'(bus.rf_addr), 64'd9);
        check("mr_post_we",   64'(bus.rf_we),   64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
